// File: rtl/fetch_pkg.sv
// Shared defaults, derived widths and helpers for the fetch line queue.
// The dual-read build is selected with FLQ_DUAL_READ_EN.
package fetch_pkg;

    localparam int FLQ_DEPTH          = 4;
    localparam int FLQ_WORDS_PER_LINE = 4;
    localparam int FLQ_WORD_WIDTH     = 32;

    localparam int FLQ_WP_W   = $clog2(FLQ_DEPTH) + 1;
    localparam int FLQ_RP_W   = $clog2(FLQ_DEPTH * FLQ_WORDS_PER_LINE) + 1;
    localparam int FLQ_OFF_W  = $clog2(FLQ_WORDS_PER_LINE);

    typedef logic [FLQ_WORDS_PER_LINE-1:0][FLQ_WORD_WIDTH-1:0] flq_line_t;

    // Requested word count before clamping against the occupancy.
    function automatic logic [1:0] flq_rd_req(input logic [1:0] rd_cnt, input logic dual);
        logic [1:0] req;
        case (rd_cnt)
            2'd0:    req = 2'd0;
            2'd1:    req = 2'd1;
            default: req = dual ? 2'd2 : 2'd1;
        endcase
        return req;
    endfunction

endpackage

// File: rtl/fetch_line_queue_word_select.sv
// Word multiplexer: picks one instruction out of the flattened line storage.
module flq_word_select
    import fetch_pkg::*;
#(
    parameter int DEPTH          = FLQ_DEPTH,
    parameter int WORDS_PER_LINE = FLQ_WORDS_PER_LINE,
    parameter int WORD_WIDTH     = FLQ_WORD_WIDTH
) (
    input  logic [DEPTH*WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] storage,
    input  logic [$clog2(DEPTH*WORDS_PER_LINE)-1:0]         ptr,
    output logic [WORD_WIDTH-1:0]                           word
);

    // Word-granular read of the storage.
    always_comb begin
        word = storage[ptr];
    end

endmodule

// File: rtl/fetch_line_queue.sv
// Line-granular instruction fetch queue presenting one or two words per cycle.
// Define FLQ_DUAL_READ_EN to build the second read port (o_instr1/o_valid1).
module fetch_line_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH          = FLQ_DEPTH,
    parameter int WORDS_PER_LINE = FLQ_WORDS_PER_LINE,
    parameter int WORD_WIDTH     = FLQ_WORD_WIDTH
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [WORDS_PER_LINE*WORD_WIDTH-1:0]   i_line,
    input  logic                                   i_wr_en,
    input  logic [1:0]                             i_rd_cnt,
    input  logic                                   i_flush,
    input  logic                                   i_flush_line_valid,
    input  logic [WORDS_PER_LINE*WORD_WIDTH-1:0]   i_flush_line,
    input  logic [$clog2(WORDS_PER_LINE)-1:0]      i_flush_offset,
    output logic [WORD_WIDTH-1:0]                  o_instr0,
    output logic [WORD_WIDTH-1:0]                  o_instr1,
    output logic                                   o_valid0,
    output logic                                   o_valid1,
    output logic                                   o_full,
    output logic                                   o_almost_full,
    output logic [$clog2(DEPTH*WORDS_PER_LINE):0]  o_count
);

    localparam int LW = $clog2(DEPTH);
    localparam int OW = $clog2(WORDS_PER_LINE);
    localparam int RW = $clog2(DEPTH * WORDS_PER_LINE);

`ifdef FLQ_DUAL_READ_EN
    localparam logic DUAL = 1'b1;
`else
    localparam logic DUAL = 1'b0;
`endif

    logic [DEPTH-1:0][WORDS_PER_LINE-1:0][WORD_WIDTH-1:0] mem_r;
    logic [LW:0]        wp_r;
    logic [RW:0]        rp_r;
    logic [RW:0]        count_s;
    logic [LW:0]        occ_s;
    logic               full_s;
    logic [1:0]         req_s;
    logic [RW:0]        req_ext_s;
    logic [RW:0]        consumed_s;
    logic [WORD_WIDTH-1:0] word0_s;

    // Occupancy and clamped read amount from the registered pointers.
    always_comb begin
        count_s    = {wp_r, {OW{1'b0}}} - rp_r;
        occ_s      = wp_r - rp_r[RW:OW];
        full_s     = (occ_s == (LW+1)'(DEPTH));
        req_s      = flq_rd_req(i_rd_cnt, DUAL);
        req_ext_s  = {{(RW-1){1'b0}}, req_s};
        if (req_ext_s > count_s) begin
            consumed_s = count_s;
        end else begin
            consumed_s = req_ext_s;
        end
    end

    // Pointer and storage update; a flush overrides both write and read.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wp_r  <= '0;
            rp_r  <= '0;
            mem_r <= '0;
        end else if (i_flush) begin
            if (i_flush_line_valid) begin
                mem_r[{LW{1'b0}}] <= i_flush_line;
                wp_r              <= (LW+1)'(1);
                rp_r              <= (RW+1)'(i_flush_offset);
            end else begin
                wp_r <= '0;
                rp_r <= '0;
            end
        end else begin
            // A write while full is dropped even if this cycle's read frees a slot.
            if (i_wr_en && !full_s) begin
                mem_r[wp_r[LW-1:0]] <= i_line;
                wp_r                <= wp_r + (LW+1)'(1);
            end
            rp_r <= rp_r + consumed_s;
        end
    end

    flq_word_select #(
        .DEPTH          (DEPTH),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .WORD_WIDTH     (WORD_WIDTH)
    ) u_sel0 (
        .storage (mem_r),
        .ptr     (rp_r[RW-1:0]),
        .word    (word0_s)
    );

`ifdef FLQ_DUAL_READ_EN
    logic [WORD_WIDTH-1:0] word1_s;
    logic [RW-1:0]         ptr1_s;

    // Second word wraps from the last slot back to slot 0 naturally.
    always_comb begin
        ptr1_s = rp_r[RW-1:0] + {{(RW-1){1'b0}}, 1'b1};
    end

    flq_word_select #(
        .DEPTH          (DEPTH),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .WORD_WIDTH     (WORD_WIDTH)
    ) u_sel1 (
        .storage (mem_r),
        .ptr     (ptr1_s),
        .word    (word1_s)
    );

    // Second read port outputs.
    always_comb begin
        o_instr1 = word1_s;
        o_valid1 = (count_s >= (RW+1)'(2));
    end
`else
    // Second read port is tied off in the single-read build.
    always_comb begin
        o_instr1 = {WORD_WIDTH{1'b0}};
        o_valid1 = 1'b0;
    end
`endif

    // Primary outputs from registered state.
    always_comb begin
        o_instr0      = word0_s;
        o_valid0      = (count_s != {(RW+1){1'b0}});
        o_full        = full_s;
        o_almost_full = (occ_s == (LW+1)'(DEPTH - 1));
        o_count       = count_s;
    end

endmodule

// File: tb/tb_fetch_line_queue.sv
// Self-checking bench for fetch_line_queue; word-queue reference model.
module tb_fetch_line_queue;
    import fetch_pkg::*;

    localparam int D   = 4;
    localparam int WPL = 4;

`ifdef FLQ_DUAL_READ_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    flq_line_t   line_s;
    logic        wr_en;
    logic [1:0]  rd_cnt;
    logic        flush;
    logic        flush_lv;
    flq_line_t   flush_line;
    logic [1:0]  flush_off;
    logic [31:0] instr0, instr1;
    logic        valid0, valid1, full, afull;
    logic [4:0]  count;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] mq[$];
    int          head_off;

    always #5 clk = ~clk;

    fetch_line_queue dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_line             (line_s),
        .i_wr_en            (wr_en),
        .i_rd_cnt           (rd_cnt),
        .i_flush            (flush),
        .i_flush_line_valid (flush_lv),
        .i_flush_line       (flush_line),
        .i_flush_offset     (flush_off),
        .o_instr0           (instr0),
        .o_instr1           (instr1),
        .o_valid0           (valid0),
        .o_valid1           (valid1),
        .o_full             (full),
        .o_almost_full      (afull),
        .o_count            (count)
    );

    function automatic int m_occ();
        return (mq.size() + head_off) / WPL;
    endfunction

    function automatic flq_line_t mk_line(input logic [31:0] b);
        flq_line_t l;
        for (int w = 0; w < WPL; w++) l[w] = b + 32'(w);
        return l;
    endfunction

    task automatic set_idle();
        wr_en = 1'b0; line_s = '0; rd_cnt = 2'd0;
        flush = 1'b0; flush_lv = 1'b0; flush_line = '0; flush_off = 2'd0;
    endtask

    // One clock: drive inputs, advance the model against pre-edge state, sample 1 ns later.
    task automatic step(input bit wr, input flq_line_t ln, input int rd,
                        input bit fl, input bit fv, input flq_line_t fln, input int foff);
        int req, cons;
        bit full_pre;
        wr_en = wr; line_s = ln; rd_cnt = 2'(rd);
        flush = fl; flush_lv = fv; flush_line = fln; flush_off = 2'(foff);
        @(posedge clk);
        full_pre = (m_occ() == D);
        req  = (rd == 0) ? 0 : (DUAL ? ((rd >= 2) ? 2 : 1) : 1);
        cons = (req < mq.size()) ? req : mq.size();
        if (fl) begin
            mq.delete();
            head_off = 0;
            if (fv) begin
                for (int w = foff; w < WPL; w++) mq.push_back(fln[w]);
                head_off = foff;
            end
        end else begin
            repeat (cons) void'(mq.pop_front());
            head_off = (head_off + cons) % WPL;
            if (wr && !full_pre)
                for (int w = 0; w < WPL; w++) mq.push_back(ln[w]);
        end
        #1;
        set_idle();
    endtask

    task automatic push(input logic [31:0] b);
        step(1'b1, mk_line(b), 0, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic rd(input int n);
        step(1'b0, '0, n, 1'b0, 1'b0, '0, 0);
    endtask

    task automatic do_reset();
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        head_off = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (count !== 5'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
        total_cnt++; if (valid0 !== 1'b0 || valid1 !== 1'b0) $display("FAIL reset_valid: got %b%b expected 00", valid0, valid1); else pass_cnt++;
        total_cnt++; if (full !== 1'b0 || afull !== 1'b0) $display("FAIL reset_full: got %b%b expected 00", full, afull); else pass_cnt++;
        total_cnt++; if (instr0 !== 32'd0 || instr1 !== 32'd0) $display("FAIL reset_instr: got %h %h expected 0 0", instr0, instr1); else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        push(32'd0);
        push(32'd4);
        total_cnt++; if (count !== 5'd8) $display("FAIL basic_count0: got %0d expected 8", count); else pass_cnt++;
`ifdef FLQ_DUAL_READ_EN
        for (int k = 0; k < 4; k++) begin
            total_cnt++; if (instr0 !== 32'(2*k) || instr1 !== 32'(2*k+1))
                $display("FAIL basic_pair%0d: got %0d,%0d expected %0d,%0d", k, instr0, instr1, 2*k, 2*k+1); else pass_cnt++;
            rd(2);
            total_cnt++; if (count !== 5'(6 - 2*k)) $display("FAIL basic_count%0d: got %0d expected %0d", k, count, 6 - 2*k); else pass_cnt++;
        end
`else
        for (int k = 0; k < 8; k++) begin
            total_cnt++; if (instr0 !== 32'(k) || valid1 !== 1'b0)
                $display("FAIL basic_word%0d: got %0d v1=%b expected %0d v1=0", k, instr0, valid1, k); else pass_cnt++;
            rd(2);
            total_cnt++; if (count !== 5'(7 - k)) $display("FAIL basic_count%0d: got %0d expected %0d", k, count, 7 - k); else pass_cnt++;
        end
`endif
        total_cnt++; if (valid0 !== 1'b0) $display("FAIL basic_empty: got v0=%b expected 0", valid0); else pass_cnt++;
    endtask

    task automatic test_full();
        do_reset();
        for (int s = 1; s <= 4; s++) push(32'h100 * s);
        total_cnt++; if (full !== 1'b1 || afull !== 1'b0 || count !== 5'd16)
            $display("FAIL full_set: got f=%b af=%b cnt=%0d expected 1 0 16", full, afull, count); else pass_cnt++;
        step(1'b1, mk_line(32'hDEAD0000), 1, 1'b0, 1'b0, '0, 0);
        total_cnt++; if (count !== 5'd15 || full !== 1'b1 || instr0 !== 32'h101)
            $display("FAIL full_drop: got cnt=%0d f=%b i0=%h expected 15 1 101", count, full, instr0); else pass_cnt++;
        rd(1);
        rd(1);
        total_cnt++; if (full !== 1'b1) $display("FAIL full_partial: got %b expected 1", full); else pass_cnt++;
        rd(1);
        total_cnt++; if (full !== 1'b0 || afull !== 1'b1 || count !== 5'd12 || instr0 !== 32'h200)
            $display("FAIL full_release: got f=%b af=%b cnt=%0d i0=%h expected 0 1 12 200", full, afull, count, instr0); else pass_cnt++;
        push(32'h500);
        total_cnt++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL full_refill: got f=%b cnt=%0d expected 1 16", full, count); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int s = 1; s <= 4; s++) push(32'h100 * s);
        repeat (4) rd(1);
        push(32'h900);
        repeat (11) rd(1);
        total_cnt++; if (count !== 5'd5 || instr0 !== 32'h403)
            $display("FAIL wrap_i0: got cnt=%0d i0=%h expected 5 403", count, instr0); else pass_cnt++;
`ifdef FLQ_DUAL_READ_EN
        total_cnt++; if (instr1 !== 32'h900 || valid1 !== 1'b1)
            $display("FAIL wrap_i1: got %h v1=%b expected 900 1", instr1, valid1); else pass_cnt++;
        rd(2);
        total_cnt++; if (count !== 5'd3 || instr0 !== 32'h901)
            $display("FAIL wrap_adv: got cnt=%0d i0=%h expected 3 901", count, instr0); else pass_cnt++;
`else
        rd(2);
        total_cnt++; if (count !== 5'd4 || instr0 !== 32'h900 || valid1 !== 1'b0)
            $display("FAIL wrap_adv: got cnt=%0d i0=%h v1=%b expected 4 900 0", count, instr0, valid1); else pass_cnt++;
`endif
    endtask

    task automatic test_underflow();
        do_reset();
        push(32'h700);
        repeat (3) rd(1);
        total_cnt++; if (count !== 5'd1 || instr0 !== 32'h703)
            $display("FAIL uf_last: got cnt=%0d i0=%h expected 1 703", count, instr0); else pass_cnt++;
        rd(2);
        total_cnt++; if (count !== 5'd0 || valid0 !== 1'b0)
            $display("FAIL uf_clamp: got cnt=%0d v0=%b expected 0 0", count, valid0); else pass_cnt++;
        rd(3);
        total_cnt++; if (count !== 5'd0) $display("FAIL uf_empty_read: got %0d expected 0", count); else pass_cnt++;
        push(32'h800);
        total_cnt++; if (count !== 5'd4 || instr0 !== 32'h800)
            $display("FAIL uf_after: got cnt=%0d i0=%h expected 4 800", count, instr0); else pass_cnt++;
    endtask

    task automatic test_flush();
        flq_line_t fl;
        do_reset();
        push(32'h10);
        push(32'h20);
        rd(1);
        fl[0] = 32'hAAAA0000; fl[1] = 32'hBBBB0000; fl[2] = 32'hCCCC0000; fl[3] = 32'hDDDD0000;
        step(1'b1, mk_line(32'hBAD0), 1, 1'b1, 1'b1, fl, 2);
        total_cnt++; if (instr0 !== 32'hCCCC0000 || count !== 5'd2 || full !== 1'b0)
            $display("FAIL flush_redirect: got i0=%h cnt=%0d f=%b expected CCCC0000 2 0", instr0, count, full); else pass_cnt++;
`ifdef FLQ_DUAL_READ_EN
        total_cnt++; if (instr1 !== 32'hDDDD0000 || valid1 !== 1'b1)
            $display("FAIL flush_i1: got %h v1=%b expected DDDD0000 1", instr1, valid1); else pass_cnt++;
`else
        total_cnt++; if (instr1 !== 32'd0 || valid1 !== 1'b0)
            $display("FAIL flush_i1: got %h v1=%b expected 0 0", instr1, valid1); else pass_cnt++;
`endif
        step(1'b0, '0, 0, 1'b1, 1'b0, '0, 0);
        total_cnt++; if (count !== 5'd0 || valid0 !== 1'b0)
            $display("FAIL flush_empty: got cnt=%0d v0=%b expected 0 0", count, valid0); else pass_cnt++;
        push(32'h600);
        total_cnt++; if (count !== 5'd4 || instr0 !== 32'h600)
            $display("FAIL flush_refill: got cnt=%0d i0=%h expected 4 600", count, instr0); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        push(32'h30);
        push(32'h40);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if (count !== 5'd0 || valid0 !== 1'b0 || instr0 !== 32'd0)
            $display("FAIL async_reset: got cnt=%0d v0=%b i0=%h expected 0 0 0", count, valid0, instr0); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        head_off = 0;
    endtask

    task automatic test_random();
        flq_line_t ln, fl;
        int r, fo;
        bit w, f, fv;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < WPL; k++) begin
                ln[k] = $urandom;
                fl[k] = $urandom;
            end
            w  = ($urandom_range(0, 2) != 0);
            r  = $urandom_range(0, 3);
            f  = ($urandom_range(0, 24) == 0);
            fv = $urandom_range(0, 1) != 0;
            fo = $urandom_range(0, WPL - 1);
            step(w, ln, r, f, fv, fl, fo);
            total_cnt++; if (count !== 5'(mq.size()))
                $display("FAIL rnd_count@%0d: got %0d expected %0d", i, count, mq.size()); else pass_cnt++;
            total_cnt++; if (valid0 !== (mq.size() >= 1) || valid1 !== (DUAL && mq.size() >= 2))
                $display("FAIL rnd_valid@%0d: got %b%b expected %b%b", i, valid0, valid1, mq.size() >= 1, DUAL && mq.size() >= 2); else pass_cnt++;
            total_cnt++; if (full !== (m_occ() == D) || afull !== (m_occ() == D - 1))
                $display("FAIL rnd_full@%0d: got f=%b af=%b expected occ=%0d", i, full, afull, m_occ()); else pass_cnt++;
            if (mq.size() >= 1) begin
                total_cnt++; if (instr0 !== mq[0])
                    $display("FAIL rnd_instr0@%0d: got %h expected %h", i, instr0, mq[0]); else pass_cnt++;
            end
`ifdef FLQ_DUAL_READ_EN
            if (mq.size() >= 2) begin
                total_cnt++; if (instr1 !== mq[1])
                    $display("FAIL rnd_instr1@%0d: got %h expected %h", i, instr1, mq[1]); else pass_cnt++;
            end
`else
            total_cnt++; if (instr1 !== 32'd0)
                $display("FAIL rnd_instr1@%0d: got %h expected 0", i, instr1); else pass_cnt++;
`endif
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        head_off = 0;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_underflow();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
